// File: rtl/rf_pkg.sv
// Shared types for the register file: load-extension mode encoding.
package rf_pkg;
    typedef logic [2:0] ext_t;

    localparam ext_t EXT_W   = 3'd0;
    localparam ext_t EXT_LB  = 3'd1;
    localparam ext_t EXT_LBU = 3'd2;
    localparam ext_t EXT_LH  = 3'd3;
    localparam ext_t EXT_LHU = 3'd4;

    function automatic logic is_half(input ext_t mode);
        return (mode == EXT_LH) || (mode == EXT_LHU);
    endfunction
endpackage

// File: rtl/rf_mp_lext_if.sv
// Decode/write-back/debug bundle of the register file; master drives, slave is the register file.
interface rf_mp_lext_if
    import rf_pkg::*;
#(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRD = 2
);
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    ext_t              wr_ext;
    logic [1:0]        wr_boff;
    logic              ld_iss;
    logic [AW-1:0]     ld_dst;
    logic              wr_err;
    logic [31:0]       wr_cnt;
    logic [AW-1:0]     dbg_sel;
    logic [DW-1:0]     dbg_data;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_ext, wr_boff, ld_iss, ld_dst, dbg_sel,
        input  rd_data, rd_busy, wr_err, wr_cnt, dbg_data
    );
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_ext, wr_boff, ld_iss, ld_dst, dbg_sel,
        output rd_data, rd_busy, wr_err, wr_cnt, dbg_data
    );
endinterface

// File: rtl/rf_load_ext.sv
// Byte/halfword lane select plus sign/zero extension of write-back data; purely combinational.
module rf_load_ext
    import rf_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] i_data,
    input  ext_t          i_ext,
    input  logic [1:0]    i_boff,
    output logic [DW-1:0] o_data,
    output logic          o_misalign
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte     = i_data[{i_boff, 3'b000} +: 8];
    assign w_half     = i_data[{i_boff[1], 4'b0000} +: 16];
    assign o_misalign = is_half(i_ext) && i_boff[0];

    always_comb begin
        o_data = i_data;
        case (i_ext)
            EXT_LB:  o_data = {{(DW-8){w_byte[7]}}, w_byte};
            EXT_LBU: o_data = {{(DW-8){1'b0}}, w_byte};
            EXT_LH:  o_data = {{(DW-16){w_half[15]}}, w_half};
            EXT_LHU: o_data = {{(DW-16){1'b0}}, w_half};
            default: o_data = i_data;
        endcase
    end
endmodule

// File: rtl/rf_mp_lext.sv
// Multi-read-port register file with load extension, write bypass, pending-load scoreboard, debug port.
// Reads are combinational; writes, busy updates, wr_err and wr_cnt update on the rising edge.
module rf_mp_lext
    import rf_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input logic          clk,
    input logic          rst,
    rf_mp_lext_if.slave  bus
);
    localparam int NREG = 2**AW;

    logic [DW-1:0]   r_rf [NREG];
    logic [NREG-1:0] r_busy;
    logic            r_wr_err;
    logic [31:0]     r_wr_cnt;

    logic [DW-1:0]   w_ext_data;
    logic [DW-1:0]   w_byp_data;
    logic            w_mis;
    logic            w_byp_mis;
    logic            w_commit;
    logic            w_byp_vld;

    rf_load_ext #(.DW(DW)) u_ext_commit (
        .i_data     (bus.wr_data),
        .i_ext      (bus.wr_ext),
        .i_boff     (bus.wr_boff),
        .o_data     (w_ext_data),
        .o_misalign (w_mis)
    );

    rf_load_ext #(.DW(DW)) u_ext_bypass (
        .i_data     (bus.wr_data),
        .i_ext      (bus.wr_ext),
        .i_boff     (bus.wr_boff),
        .o_data     (w_byp_data),
        .o_misalign (w_byp_mis)
    );

    assign w_commit  = bus.wr_en && (bus.wr_addr != '0) && !w_mis;
    assign w_byp_vld = (BYPASS != 0) && bus.wr_en && (bus.wr_addr != '0) && !w_byp_mis;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
            r_busy   <= '0;
            r_wr_err <= 1'b0;
            r_wr_cnt <= '0;
        end else begin
            r_wr_err <= bus.wr_en && w_mis;
            if (w_commit) begin
                r_rf[bus.wr_addr] <= w_ext_data;
                r_wr_cnt          <= r_wr_cnt + 32'd1;
            end
            // Clear first so a same-edge re-issue to the same register leaves it busy.
            if (bus.wr_en) begin
                r_busy[bus.wr_addr] <= 1'b0;
            end
            if (bus.ld_iss && (bus.ld_dst != '0)) begin
                r_busy[bus.ld_dst] <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            logic [AW-1:0] w_ra;
            w_ra = bus.rd_addr[k*AW +: AW];
            if (w_ra == '0) begin
                bus.rd_data[k*DW +: DW] = '0;
            end else if (w_byp_vld && (w_ra == bus.wr_addr)) begin
                bus.rd_data[k*DW +: DW] = w_byp_data;
            end else begin
                bus.rd_data[k*DW +: DW] = r_rf[w_ra];
            end
            // A write in flight to this register retires its load unless a new load re-targets it.
            if ((BYPASS != 0) && bus.wr_en && (w_ra == bus.wr_addr)
                && !(bus.ld_iss && (bus.ld_dst == w_ra))) begin
                bus.rd_busy[k] = 1'b0;
            end else begin
                bus.rd_busy[k] = r_busy[w_ra];
            end
        end
    end

    assign bus.dbg_data = r_rf[bus.dbg_sel];
    assign bus.wr_err   = r_wr_err;
    assign bus.wr_cnt   = r_wr_cnt;
endmodule
